// File: rtl/mult_sweep_pkg.sv
// Shared constants and state encoding for the multiple-checker sweep driver.
// Widths are fixed by the attached combinational checker (5-bit operand,
// 3-bit select), so they live here rather than as per-instance parameters.
package mult_sweep_pkg;

   // Operand width; the sweep covers 0 .. 2**OPW-1.
   localparam int OPW  = 5;
   // Divisor select width; divisor = select + 2.
   localparam int SELW = 3;
   // Hit-count width; must be able to hold 2**OPW (every operand a hit).
   localparam int CNTW = 6;

   // Last operand of the sweep; reaching it ends the SWEEP phase.
   localparam logic [OPW-1:0] A_MAX = OPW'((1 << OPW) - 1);

   // Controller phases: waiting for a request, walking the operands,
   // presenting the tally until the consumer takes it.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage : mult_sweep_pkg

// File: rtl/mult_sweep_counter.sv
// Sequential driver/collector for the combinational multiple-checker.
// On an accepted start it latches the divisor select, walks the operand
// 0..A_MAX through the checker one value per cycle, counts the reported hits
// and offers the tally on a valid/ready handshake.
//
// Optional feature: define MULT_SWEEP_LASTHIT_EN to add the last_hit output,
// which reports the largest operand the checker flagged during the sweep.
module mult_sweep_counter
   import mult_sweep_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SELW-1:0] sel_in,
   output logic            busy,
   output logic [OPW-1:0]  chk_a,
   output logic [SELW-1:0] chk_sel,
   input  logic            chk_hit,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [CNTW-1:0] res_count
`ifdef MULT_SWEEP_LASTHIT_EN
   ,
   output logic [OPW-1:0]  last_hit
`endif
);

   state_t state;

   // Sweep controller: state, checker operands, hit tally and handshake flags
   // all registered together so every output changes on the same edge.
   // NOTE: sequential state is assigned with <= only, so every register here
   // samples the pre-edge values of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         res_count <= '0;
         chk_a     <= '0;
         chk_sel   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               // A request is only honoured here; select is captured once and
               // held on chk_sel for the whole sweep.
               if (start) begin
                  state     <= SWEEP;
                  busy      <= 1'b1;
                  chk_sel   <= sel_in;
                  chk_a     <= '0;
                  res_count <= '0;
               end
            end

            SWEEP: begin
               // chk_hit is the checker's same-cycle answer for chk_a/chk_sel.
               res_count <= res_count + CNTW'(chk_hit);
               if (chk_a == A_MAX) begin
                  // chk_a stays at A_MAX; it never wraps back to 0.
                  state     <= HOLD;
                  res_valid <= 1'b1;
               end else begin
                  chk_a <= chk_a + OPW'(1);
               end
            end

            HOLD: begin
               // Result stays stable until taken; start here is dropped,
               // a new sweep needs a fresh request in IDLE.
               if (res_ready) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  res_valid <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef MULT_SWEEP_LASTHIT_EN
   // Largest flagged operand: the sweep is ascending, so the most recent hit
   // is the largest one; stays 0 when nothing hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_hit <= '0;
      end else if (state == IDLE && start) begin
         last_hit <= '0;
      end else if (state == SWEEP && chk_hit) begin
         last_hit <= chk_a;
      end
   end
`endif

endmodule : mult_sweep_counter
